// File: rtl/rob_dual_commit_pkg.sv
// rob_dual_commit shared definitions
// instruction codes, store states, type predicates
package rob_dual_commit_pkg;

  localparam int INST_TYPE_W = 6;
  localparam int REG_W       = 5;

  localparam logic [INST_TYPE_W-1:0] T_NOP  = 6'd0;
  localparam logic [INST_TYPE_W-1:0] T_ADD  = 6'd1;
  localparam logic [INST_TYPE_W-1:0] T_LW   = 6'd2;
  localparam logic [INST_TYPE_W-1:0] T_BEQ  = 6'd10;
  localparam logic [INST_TYPE_W-1:0] T_BNE  = 6'd11;
  localparam logic [INST_TYPE_W-1:0] T_BLT  = 6'd12;
  localparam logic [INST_TYPE_W-1:0] T_BGE  = 6'd13;
  localparam logic [INST_TYPE_W-1:0] T_BLTU = 6'd14;
  localparam logic [INST_TYPE_W-1:0] T_BGEU = 6'd15;
  localparam logic [INST_TYPE_W-1:0] T_SB   = 6'd16;
  localparam logic [INST_TYPE_W-1:0] T_SH   = 6'd17;
  localparam logic [INST_TYPE_W-1:0] T_SW   = 6'd18;
  localparam logic [INST_TYPE_W-1:0] T_JAL  = 6'd19;
  localparam logic [INST_TYPE_W-1:0] T_JALR = 6'd20;

  typedef enum logic {
    ROB_ST_IDLE = 1'b0,
    ROB_ST_WAIT = 1'b1
  } rob_st_e;

  function automatic logic is_branch(
    input logic [INST_TYPE_W-1:0] t
  );
    return t inside {T_BEQ, T_BNE, T_BLT,
                     T_BGE, T_BLTU, T_BGEU};
  endfunction

  function automatic logic is_store(
    input logic [INST_TYPE_W-1:0] t
  );
    return t inside {T_SB, T_SH, T_SW};
  endfunction

  function automatic logic is_jump(
    input logic [INST_TYPE_W-1:0] t
  );
    return t inside {T_JAL, T_JALR};
  endfunction

  // anything that must retire alone in slot 0
  function automatic logic is_solo(
    input logic [INST_TYPE_W-1:0] t
  );
    return is_branch(t) | is_jump(t) | is_store(t);
  endfunction

endpackage

// File: rtl/rob_store_port.sv
// rob_store_port: store request FSM
// holds bus request and payload until ack
module rob_store_port
  import rob_dual_commit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   start,
  input  logic                   ack,
  input  logic [DATA_W-1:0]      ld_addr,
  input  logic [DATA_W-1:0]      ld_data,
  input  logic [INST_TYPE_W-1:0] ld_kind,
  output logic                   idle,
  output logic                   done,
  output logic                   req,
  output logic [DATA_W-1:0]      addr,
  output logic [DATA_W-1:0]      data,
  output logic [INST_TYPE_W-1:0] kind
);

  rob_st_e state, state_nx;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ROB_ST_IDLE;
    else     state <= state_nx;
  end

  // next state; done marks the ack cycle
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    unique case (state)
      ROB_ST_IDLE: begin
        if (rdy && start) state_nx = ROB_ST_WAIT;
      end
      ROB_ST_WAIT: begin
        if (rdy && ack) begin
          state_nx = ROB_ST_IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = ROB_ST_IDLE;
    endcase
  end

  // capture payload as the request launches
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      data <= '0;
      kind <= '0;
    end else if (rdy && start && idle) begin
      addr <= ld_addr;
      data <= ld_data;
      kind <= ld_kind;
    end
  end

  assign idle = (state == ROB_ST_IDLE);
  assign req  = (state == ROB_ST_WAIT);

endmodule

// File: rtl/rob_dual_commit.sv
// rob_dual_commit: reorder buffer with
// N writeback ports and dual in-order commit
module rob_dual_commit
  import rob_dual_commit_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int PTR_W    = 5,
  parameter int NUM_WB   = 3,
  parameter int COMMIT_W = 2,
  parameter int DATA_W   = 32
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       alloc_en_in,
  input  logic [INST_TYPE_W-1:0]     alloc_type_in,
  input  logic [REG_W-1:0]           alloc_reg_in,
  output logic [PTR_W-1:0]           alloc_idx_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic [PTR_W:0]             count_out,
  input  logic [PTR_W-1:0]           rs1_idx_in,
  input  logic [PTR_W-1:0]           rs2_idx_in,
  output logic                       rs1_rdy_out,
  output logic                       rs2_rdy_out,
  output logic [DATA_W-1:0]          rs1_data_out,
  output logic [DATA_W-1:0]          rs2_data_out,
  input  logic [NUM_WB-1:0]          wb_en_in,
  input  logic [NUM_WB*PTR_W-1:0]    wb_idx_in,
  input  logic [NUM_WB*DATA_W-1:0]   wb_value_in,
  input  logic [NUM_WB*DATA_W-1:0]   wb_addr_in,
  input  logic [NUM_WB-1:0]          wb_mispred_in,
  output logic                       st_req_out,
  output logic [DATA_W-1:0]          st_addr_out,
  output logic [DATA_W-1:0]          st_data_out,
  output logic [INST_TYPE_W-1:0]     st_type_out,
  input  logic                       st_ack_in,
  output logic [COMMIT_W-1:0]        commit_en_out,
  output logic [COMMIT_W*REG_W-1:0]  commit_reg_out,
  output logic [COMMIT_W*PTR_W-1:0]  commit_idx_out,
  output logic [COMMIT_W*DATA_W-1:0] commit_value_out,
  output logic                       flush_out,
  output logic [DATA_W-1:0]          redirect_pc_out
);

  localparam int CW = PTR_W + 1;

  logic [DEPTH-1:0]       busy_q, ready_q, mis_q;
  logic [INST_TYPE_W-1:0] type_q [DEPTH];
  logic [REG_W-1:0]       reg_q  [DEPTH];
  logic [DATA_W-1:0]      val_q  [DEPTH];
  logic [DATA_W-1:0]      addr_q [DEPTH];

  logic [PTR_W-1:0] head, tail, h1;
  logic [CW-1:0]    count;

  logic [PTR_W-1:0]  wb_tag [NUM_WB];
  logic [DATA_W-1:0] wb_val [NUM_WB];
  logic [DATA_W-1:0] wb_adr [NUM_WB];

  logic [INST_TYPE_W-1:0] t0, t1;
  logic full, ok0, ok1, ret0, ret1;
  logic flush, alloc_ok;
  logic st_start, st_idle, st_done;
  logic [1:0] n_ret;

  logic [1:0]          cm_en;
  logic [2*REG_W-1:0]  cm_reg;
  logic [2*PTR_W-1:0]  cm_idx;
  logic [2*DATA_W-1:0] cm_val;
  logic                flush_q;
  logic [DATA_W-1:0]   redirect_q;

  for (genvar c = 0; c < NUM_WB; c++) begin : g_wb
    assign wb_tag[c] = wb_idx_in[c*PTR_W +: PTR_W];
    assign wb_val[c] = wb_value_in[c*DATA_W +: DATA_W];
    assign wb_adr[c] = wb_addr_in[c*DATA_W +: DATA_W];
  end

  assign h1   = head + PTR_W'(1);
  assign t0   = type_q[head];
  assign t1   = type_q[h1];
  assign full = (count == CW'(DEPTH));
  assign ok0  = busy_q[head] & ready_q[head];
  assign ok1  = busy_q[h1] & ready_q[h1];

  assign ret0 = rdy_in & ok0 & st_idle
              & ~is_store(t0);
  assign ret1 = (COMMIT_W == 2) & ret0 & ok1
              & ~is_solo(t0) & ~is_solo(t1);

  assign st_start = rdy_in & ok0 & st_idle
                  & is_store(t0);
  assign flush    = ret0 & mis_q[head]
                  & (is_branch(t0) | is_jump(t0));
  assign alloc_ok = rdy_in & alloc_en_in & ~full;
  assign n_ret    = {1'b0, ret0 | st_done}
                  + {1'b0, ret1};

  rob_store_port #(
    .DATA_W (DATA_W)
  ) u_st (
    .clk     (clk_in),
    .rst     (rst_in),
    .rdy     (rdy_in),
    .start   (st_start),
    .ack     (st_ack_in),
    .ld_addr (addr_q[head]),
    .ld_data (val_q[head]),
    .ld_kind (t0),
    .idle    (st_idle),
    .done    (st_done),
    .req     (st_req_out),
    .addr    (st_addr_out),
    .data    (st_data_out),
    .kind    (st_type_out)
  );

  // entry array, pointers and occupancy
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      busy_q  <= '0;
      ready_q <= '0;
      mis_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i] <= '0;
        reg_q[i]  <= '0;
        val_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush) begin
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        busy_q  <= '0;
        ready_q <= '0;
        mis_q   <= '0;
      end else begin
        // descending so channel 0 lands last
        for (int c = NUM_WB - 1; c >= 0; c--) begin
          if (wb_en_in[c] && busy_q[wb_tag[c]]) begin
            ready_q[wb_tag[c]] <= 1'b1;
            val_q[wb_tag[c]]   <= wb_val[c];
            addr_q[wb_tag[c]]  <= wb_adr[c];
            mis_q[wb_tag[c]]   <= wb_mispred_in[c];
          end
        end
        if (ret0 || st_done) begin
          busy_q[head]  <= 1'b0;
          ready_q[head] <= 1'b0;
        end
        if (ret1) begin
          busy_q[h1]  <= 1'b0;
          ready_q[h1] <= 1'b0;
        end
        if (alloc_ok) begin
          busy_q[tail]  <= 1'b1;
          ready_q[tail] <= 1'b0;
          mis_q[tail]   <= 1'b0;
          type_q[tail]  <= alloc_type_in;
          reg_q[tail]   <= alloc_reg_in;
          tail          <= tail + PTR_W'(1);
        end
        head  <= head + PTR_W'(n_ret);
        count <= count + CW'(alloc_ok)
               - CW'(n_ret);
      end
    end
  end

  // registered commit and flush pulses
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cm_en      <= '0;
      cm_reg     <= '0;
      cm_idx     <= '0;
      cm_val     <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      cm_en   <= '0;
      flush_q <= 1'b0;
      if (ret0) begin
        cm_en  <= {ret1, ~is_branch(t0)};
        cm_reg <= {reg_q[h1], reg_q[head]};
        cm_idx <= {h1, head};
        cm_val <= {val_q[h1], val_q[head]};
      end
      if (flush) begin
        flush_q    <= 1'b1;
        redirect_q <= addr_q[head];
      end
    end
  end

  // operand lookup with writeback bypass
  always_comb begin
    rs1_rdy_out  = ready_q[rs1_idx_in];
    rs1_data_out = val_q[rs1_idx_in];
    rs2_rdy_out  = ready_q[rs2_idx_in];
    rs2_data_out = val_q[rs2_idx_in];
    for (int c = NUM_WB - 1; c >= 0; c--) begin
      if (wb_en_in[c] && wb_tag[c] == rs1_idx_in) begin
        rs1_rdy_out  = 1'b1;
        rs1_data_out = wb_val[c];
      end
      if (wb_en_in[c] && wb_tag[c] == rs2_idx_in) begin
        rs2_rdy_out  = 1'b1;
        rs2_data_out = wb_val[c];
      end
    end
  end

  assign alloc_idx_out    = tail;
  assign full_out         = full;
  assign empty_out        = (count == '0);
  assign count_out        = count;
  assign commit_en_out    = cm_en[COMMIT_W-1:0];
  assign commit_reg_out   = cm_reg[COMMIT_W*REG_W-1:0];
  assign commit_idx_out   = cm_idx[COMMIT_W*PTR_W-1:0];
  assign commit_value_out = cm_val[COMMIT_W*DATA_W-1:0];
  assign flush_out        = flush_q;
  assign redirect_pc_out  = redirect_q;

endmodule

// File: tb/tb_rob_dual_commit.sv
// tb_rob_dual_commit: directed steps then
// random traffic against a queue model
module tb_rob_dual_commit;
  import rob_dual_commit_pkg::*;

  localparam int DEPTH  = 32;
  localparam int PTR_W  = 5;
  localparam int NUM_WB = 3;
  localparam int CMT_W  = 2;
  localparam int DW     = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in, rdy_in;
  logic alloc_en_in;
  logic [INST_TYPE_W-1:0] alloc_type_in;
  logic [REG_W-1:0] alloc_reg_in;
  logic [PTR_W-1:0] alloc_idx_out;
  logic full_out, empty_out;
  logic [PTR_W:0] count_out;
  logic [PTR_W-1:0] rs1_idx_in, rs2_idx_in;
  logic rs1_rdy_out, rs2_rdy_out;
  logic [DW-1:0] rs1_data_out, rs2_data_out;
  logic [NUM_WB-1:0] wb_en_in, wb_mispred_in;
  logic [NUM_WB*PTR_W-1:0] wb_idx_in;
  logic [NUM_WB*DW-1:0] wb_value_in, wb_addr_in;
  logic st_req_out, st_ack_in;
  logic [DW-1:0] st_addr_out, st_data_out;
  logic [INST_TYPE_W-1:0] st_type_out;
  logic [CMT_W-1:0] commit_en_out;
  logic [CMT_W*REG_W-1:0] commit_reg_out;
  logic [CMT_W*PTR_W-1:0] commit_idx_out;
  logic [CMT_W*DW-1:0] commit_value_out;
  logic flush_out;
  logic [DW-1:0] redirect_pc_out;

  rob_dual_commit #(
    .DEPTH (DEPTH), .PTR_W (PTR_W),
    .NUM_WB (NUM_WB), .COMMIT_W (CMT_W),
    .DATA_W (DW)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .alloc_en_in      (alloc_en_in),
    .alloc_type_in    (alloc_type_in),
    .alloc_reg_in     (alloc_reg_in),
    .alloc_idx_out    (alloc_idx_out),
    .full_out         (full_out),
    .empty_out        (empty_out),
    .count_out        (count_out),
    .rs1_idx_in       (rs1_idx_in),
    .rs2_idx_in       (rs2_idx_in),
    .rs1_rdy_out      (rs1_rdy_out),
    .rs2_rdy_out      (rs2_rdy_out),
    .rs1_data_out     (rs1_data_out),
    .rs2_data_out     (rs2_data_out),
    .wb_en_in         (wb_en_in),
    .wb_idx_in        (wb_idx_in),
    .wb_value_in      (wb_value_in),
    .wb_addr_in       (wb_addr_in),
    .wb_mispred_in    (wb_mispred_in),
    .st_req_out       (st_req_out),
    .st_addr_out      (st_addr_out),
    .st_data_out      (st_data_out),
    .st_type_out      (st_type_out),
    .st_ack_in        (st_ack_in),
    .commit_en_out    (commit_en_out),
    .commit_reg_out   (commit_reg_out),
    .commit_idx_out   (commit_idx_out),
    .commit_value_out (commit_value_out),
    .flush_out        (flush_out),
    .redirect_pc_out  (redirect_pc_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int                     tag;
    logic [INST_TYPE_W-1:0] ty;
    logic [REG_W-1:0]       rg;
    logic [DW-1:0]          val;
    bit                     rdy;
  } ent_t;

  ent_t q[$];
  int   next_tag;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rdy_in        = 1'b1;
    alloc_en_in   = 1'b0;
    alloc_type_in = '0;
    alloc_reg_in  = '0;
    rs1_idx_in    = '0;
    rs2_idx_in    = '0;
    wb_en_in      = '0;
    wb_idx_in     = '0;
    wb_value_in   = '0;
    wb_addr_in    = '0;
    wb_mispred_in = '0;
    st_ack_in     = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic set_wb(input int c, input int tg,
                        input logic [DW-1:0] v,
                        input logic [DW-1:0] a,
                        input logic m);
    wb_en_in[c]               = 1'b1;
    wb_idx_in[c*PTR_W +: PTR_W] = PTR_W'(tg);
    wb_value_in[c*DW +: DW]   = v;
    wb_addr_in[c*DW +: DW]    = a;
    wb_mispred_in[c]          = m;
  endtask

  task automatic alloc1(input logic [INST_TYPE_W-1:0] t,
                        input int r);
    alloc_en_in   = 1'b1;
    alloc_type_in = t;
    alloc_reg_in  = REG_W'(r);
    tick();
    alloc_en_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  logic [1:0]  exp_en;
  logic [9:0]  exp_reg, exp_idx;
  logic [63:0] exp_val;
  logic [DW-1:0] exp_dat;
  bit found, full_pre, pair;
  bit claimed [DEPTH];
  int r, tg;
  ent_t e;

  initial begin
    rst_in = 1'b1;
    clear_in();
    tick();
    tick();
    rst_in = 1'b0;

    // reset state
    chk("rst_count", count_out, 0);
    chk("rst_empty", empty_out, 1);
    chk("rst_full", full_out, 0);
    chk("rst_aidx", alloc_idx_out, 0);
    chk("rst_cen", commit_en_out, 0);
    chk("rst_flush", flush_out, 0);
    chk("rst_streq", st_req_out, 0);
    chk("rst_rs1rdy", rs1_rdy_out, 0);

    // fill all 32 slots, then one more
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_aidx", alloc_idx_out, i);
      alloc_en_in   = 1'b1;
      alloc_type_in = T_ADD;
      alloc_reg_in  = 5'd1;
      tick();
    end
    chk("fill_full", full_out, 1);
    chk("fill_count", count_out, 32);
    tick();
    alloc_en_in = 1'b0;
    chk("over_count", count_out, 32);
    chk("over_full", full_out, 1);

    // dual commit
    do_reset();
    alloc1(T_ADD, 5);
    alloc1(T_ADD, 6);
    set_wb(0, 0, 32'd7, 0, 0);
    set_wb(1, 1, 32'd9, 0, 0);
    tick();
    clear_in();
    chk("dual_cnt_pre", count_out, 2);
    tick();
    chk("dual_en", commit_en_out, 2'b11);
    chk("dual_reg", commit_reg_out, {5'd6, 5'd5});
    chk("dual_val", commit_value_out,
        {32'd9, 32'd7});
    chk("dual_idx", commit_idx_out, {5'd1, 5'd0});
    chk("dual_cnt", count_out, 0);
    tick();
    chk("dual_en_off", commit_en_out, 0);

    // rdy_in low holds everything
    alloc1(T_ADD, 7);
    set_wb(0, 2, 32'h77, 0, 0);
    tick();
    clear_in();
    rdy_in = 1'b0;
    tick();
    chk("frz_cen", commit_en_out, 0);
    chk("frz_cnt", count_out, 1);
    rdy_in = 1'b1;
    tick();
    chk("unfrz_cen", commit_en_out, 2'b01);
    chk("unfrz_val", commit_value_out[31:0],
        32'h77);
    chk("unfrz_cnt", count_out, 0);

    // store handshake
    do_reset();
    alloc1(T_SW, 0);
    set_wb(0, 0, 32'hAB, 32'h100, 0);
    tick();
    clear_in();
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("st_req", st_req_out, 1);
      chk("st_addr", st_addr_out, 32'h100);
      chk("st_data", st_data_out, 32'hAB);
      chk("st_type", st_type_out, T_SW);
      chk("st_cnt_hold", count_out, 1);
      if (k == 3) st_ack_in = 1'b1;
      tick();
    end
    st_ack_in = 1'b0;
    chk("st_req_off", st_req_out, 0);
    chk("st_cnt", count_out, 0);
    chk("st_empty", empty_out, 1);
    chk("st_cen", commit_en_out, 0);

    // mispredicted branch with younger work
    do_reset();
    alloc1(T_BEQ, 0);
    for (int i = 0; i < 5; i++) alloc1(T_ADD, i + 1);
    set_wb(0, 0, 32'd1, 32'h2000, 1'b1);
    tick();
    clear_in();
    alloc_en_in   = 1'b1;
    alloc_type_in = T_ADD;
    tick();
    alloc_en_in = 1'b0;
    chk("br_flush", flush_out, 1);
    chk("br_pc", redirect_pc_out, 32'h2000);
    chk("br_cnt", count_out, 0);
    chk("br_empty", empty_out, 1);
    chk("br_aidx", alloc_idx_out, 0);
    chk("br_cen", commit_en_out, 0);
    tick();
    chk("br_flush_off", flush_out, 0);
    chk("br_cnt2", count_out, 0);

    // operand bypass
    for (int i = 0; i < 4; i++) alloc1(T_ADD, 3);
    rs1_idx_in = 5'd3;
    rs2_idx_in = 5'd2;
    set_wb(2, 3, 32'h55, 0, 0);
    #1;
    chk("byp_rdy", rs1_rdy_out, 1);
    chk("byp_dat", rs1_data_out, 32'h55);
    chk("byp_rs2", rs2_rdy_out, 0);
    set_wb(0, 3, 32'h66, 0, 0);
    #1;
    chk("byp_low_dat", rs1_data_out, 32'h66);
    tick();
    wb_en_in = '0;
    #1;
    chk("byp_st_rdy", rs1_rdy_out, 1);
    chk("byp_st_dat", rs1_data_out, 32'h66);
    chk("byp_nocommit", count_out, 4);

    // reset during store wait
    do_reset();
    alloc1(T_SW, 0);
    set_wb(1, 0, 32'h12, 32'h40, 0);
    tick();
    clear_in();
    tick();
    chk("rw_req", st_req_out, 1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("rw_req_off", st_req_out, 0);
    chk("rw_cnt", count_out, 0);
    st_ack_in = 1'b1;
    tick();
    st_ack_in = 1'b0;
    chk("rw_ack_req", st_req_out, 0);
    chk("rw_ack_cnt", count_out, 0);
    chk("rw_ack_empty", empty_out, 1);

    // mispredicted JAL writes link and flushes
    do_reset();
    alloc1(T_JAL, 1);
    alloc1(T_ADD, 2);
    set_wb(1, 0, 32'h44, 32'h300, 1'b1);
    set_wb(2, 1, 32'h88, 0, 0);
    tick();
    clear_in();
    tick();
    chk("jal_cen", commit_en_out, 2'b01);
    chk("jal_reg", commit_reg_out[4:0], 1);
    chk("jal_val", commit_value_out[31:0], 32'h44);
    chk("jal_flush", flush_out, 1);
    chk("jal_pc", redirect_pc_out, 32'h300);
    chk("jal_cnt", count_out, 0);

    // random traffic against queue model
    do_reset();
    q.delete();
    next_tag = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      clear_in();
      rdy_in      = ($urandom_range(0, 9) != 0);
      alloc_en_in = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 19);
      alloc_type_in = (r < 14) ? T_ADD :
                      (r < 17) ? T_BEQ : T_JAL;
      alloc_reg_in = REG_W'($urandom_range(1, 31));
      for (int c = 0; c < NUM_WB; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (q.size() > 0 &&
              $urandom_range(0, 4) != 0)
            tg = q[$urandom_range(0, q.size()-1)].tag;
          else
            tg = $urandom_range(0, DEPTH-1);
          set_wb(c, tg, $urandom, $urandom, 1'b0);
        end
      end
      rs1_idx_in = PTR_W'($urandom_range(0, 31));
      #1;

      found   = 0;
      exp_dat = '0;
      for (int c = 0; c < NUM_WB; c++)
        if (!found && wb_en_in[c] &&
            wb_idx_in[c*PTR_W +: PTR_W] == rs1_idx_in)
        begin
          found   = 1;
          exp_dat = wb_value_in[c*DW +: DW];
        end
      for (int i = 0; i < q.size(); i++)
        if (!found && q[i].tag == int'(rs1_idx_in)
            && q[i].rdy) begin
          found   = 1;
          exp_dat = q[i].val;
        end
      chk("rnd_rs1_rdy", rs1_rdy_out, found);
      if (found)
        chk("rnd_rs1_dat", rs1_data_out, exp_dat);

      exp_en  = '0;
      exp_reg = '0;
      exp_idx = '0;
      exp_val = '0;
      full_pre = (q.size() == DEPTH);
      if (rdy_in) begin
        if (q.size() > 0 && q[0].rdy) begin
          exp_en[0]    = (q[0].ty != T_BEQ);
          exp_reg[4:0] = q[0].rg;
          exp_idx[4:0] = 5'(q[0].tag);
          exp_val[31:0] = q[0].val;
          pair = q.size() > 1 && q[1].rdy &&
                 q[0].ty == T_ADD && q[1].ty == T_ADD;
          if (pair) begin
            exp_en[1]     = 1'b1;
            exp_reg[9:5]  = q[1].rg;
            exp_idx[9:5]  = 5'(q[1].tag);
            exp_val[63:32] = q[1].val;
            void'(q.pop_front());
          end
          void'(q.pop_front());
        end
        for (int i = 0; i < DEPTH; i++)
          claimed[i] = 0;
        for (int c = 0; c < NUM_WB; c++) begin
          tg = int'(wb_idx_in[c*PTR_W +: PTR_W]);
          if (wb_en_in[c] && !claimed[tg]) begin
            claimed[tg] = 1;
            for (int i = 0; i < q.size(); i++)
              if (q[i].tag == tg) begin
                q[i].val = wb_value_in[c*DW +: DW];
                q[i].rdy = 1;
              end
          end
        end
        if (alloc_en_in && !full_pre) begin
          e.tag = next_tag;
          e.ty  = alloc_type_in;
          e.rg  = alloc_reg_in;
          e.val = '0;
          e.rdy = 0;
          q.push_back(e);
          next_tag = (next_tag + 1) % DEPTH;
        end
      end

      tick();
      chk("rnd_cen", commit_en_out, exp_en);
      if (exp_en[0]) begin
        chk("rnd_reg0", commit_reg_out[4:0],
            exp_reg[4:0]);
        chk("rnd_idx0", commit_idx_out[4:0],
            exp_idx[4:0]);
        chk("rnd_val0", commit_value_out[31:0],
            exp_val[31:0]);
      end
      if (exp_en[1]) begin
        chk("rnd_reg1", commit_reg_out[9:5],
            exp_reg[9:5]);
        chk("rnd_idx1", commit_idx_out[9:5],
            exp_idx[9:5]);
        chk("rnd_val1", commit_value_out[63:32],
            exp_val[63:32]);
      end
      chk("rnd_cnt", count_out, q.size());
      chk("rnd_aidx", alloc_idx_out, next_tag);
      chk("rnd_full", full_out, q.size() == DEPTH);
      chk("rnd_empty", empty_out, q.size() == 0);
      chk("rnd_flush", flush_out, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rob_dual_commit.md
Name: rob_dual_commit

Overview:
- Parametrised reorder buffer; successor to the single-commit ROB.
- Sits between dispatcher/instqueue, the writeback sources (ALU CDB, load buffer, address unit), the register file, the RAM bus store path and the fetch unit.
- Adds configurable depth, N writeback channels with same-cycle operand bypass, occupancy-counted full/empty (all DEPTH slots usable), and up to two commits per cycle.
- Flush occurs only on reported misprediction, not on every taken branch or jump.

Parameters:
- DEPTH, 32, entries; power of two, at least 4.
- PTR_W, 5, log2(DEPTH).
- NUM_WB, 3, writeback channels.
- COMMIT_W, 2, max retirements per cycle; legal values 1 or 2.
- DATA_W, 32, value and address width.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; low freezes all state.
- alloc_en_in  in  1  dispatch request.
- alloc_type_in  in  `INST_TYPE_WIDTH  instruction type.
- alloc_reg_in  in  `REGISTER_WIDTH  destination register.
- alloc_idx_out  out  PTR_W  tail index, i.e. the tag granted this cycle.
- full_out  out  1  count==DEPTH.
- empty_out  out  1  count==0.
- count_out  out  PTR_W+1  occupancy.
- rs1_idx_in, rs2_idx_in  in  PTR_W  operand tags.
- rs1_rdy_out, rs2_rdy_out  out  1  operand ready, including bypass.
- rs1_data_out, rs2_data_out  out  DATA_W  operand value.
- wb_en_in  in  NUM_WB  per-channel valid.
- wb_idx_in  in  NUM_WB*PTR_W  tag per channel.
- wb_value_in  in  NUM_WB*DATA_W  result, store data, or branch-taken flag.
- wb_addr_in  in  NUM_WB*DATA_W  store address or correct next PC.
- wb_mispred_in  in  NUM_WB  redirect required (branch/JAL/JALR only).
- st_req_out  out  1  store request to RAM bus.
- st_addr_out, st_data_out  out  DATA_W  store address and data.
- st_type_out  out  `INST_TYPE_WIDTH  SB/SH/SW.
- st_ack_in  in  1  store done.
- commit_en_out  out  COMMIT_W  per-slot register write.
- commit_reg_out  out  COMMIT_W*`REGISTER_WIDTH  destination register per slot.
- commit_idx_out  out  COMMIT_W*PTR_W  retired tag per slot.
- commit_value_out  out  COMMIT_W*DATA_W  value per slot.
- flush_out  out  1  pipeline flush pulse.
- redirect_pc_out  out  DATA_W  new fetch PC, valid with flush_out.

Behaviour:
- Reset (rst_in high at posedge):
  - head=tail=count=0; all entries non-busy and not ready; store FSM IDLE.
  - All outputs 0, except empty_out=1 and alloc_idx_out=0.
  - A store in flight is abandoned: st_req_out is low the next cycle; the bus must tolerate a dropped request.
- rdy_in low: all state holds; commit_en_out and flush_out are forced 0 that cycle; st_req_out holds.
- Allocation:
  - Accepted iff alloc_en_in && !full_out, with full_out taken from the registered count.
  - Entry becomes busy and not ready; tail wraps naturally at DEPTH.
  - alloc_en_in while full is ignored, even if a commit frees a slot in the same cycle.
- Writeback:
  - Each enabled channel writes value/addr/mispred and sets ready, only if the target entry is busy; otherwise it is ignored.
  - Two channels on the same tag: lowest channel index wins.
- Operand bypass (combinational): rsX_rdy_out=1 if the entry is ready or any wb channel targets it this cycle; data comes from the bypass when matched.
- Commit eligibility:
  - Slot 0 = head, retires if busy && ready.
  - Slot 1 = head+1, retires only if slot 0 retires, slot 1 is busy && ready, and neither entry is branch, jump or store.
  - COMMIT_W=1 disables slot 1.
- Per-type commit action:
  - Non-control op: register write on commit_en_out, registered, one cycle after the retire decision.
  - Branch: no register write. mispred=1 → flush_out=1, redirect_pc_out=addr, head=tail=count=0, all entries cleared. mispred=0 → simply retired.
  - JAL/JALR: register write in slot 0; if mispred, a flush follows in the same registered cycle.
- Store FSM, IDLE→WAIT:
  - In IDLE, with a ready store at head, st_req_out rises the next cycle with addr/data/type.
  - In WAIT, request and payload are held until st_ack_in.
  - On the ack cycle the head retires, count decrements and state returns to IDLE; st_req_out is low the following cycle.
  - No other commit occurs while in WAIT.
- Count update: count_next = count + accepted_alloc − retired; simultaneous alloc and commit are legal.
- Flush priority: a flush cycle drops any same-cycle alloc and writebacks. alloc_idx_out=0 the next cycle.

Decomposition:
- Shared package (define.vh):
  - Existing `INST_TYPE_WIDTH, `REGISTER_WIDTH and type codes `BEQ..`BGEU, `SB..`SW, `JAL, `JALR.
  - New `ROB_ST_IDLE / `ROB_ST_WAIT.
  - Helper predicates is_branch, is_store, is_jump.
- One sub-module: rob_store_port (store FSM and bus payload register).

Test Plan:
- Reset, then 32 allocs with no writeback → alloc_idx_out 0..31, full_out=1 after the 32nd; a 33rd alloc is ignored and count_out stays 32.
- Alloc add→x5 (tag 0) and add→x6 (tag 1); wb tag0=7, tag1=9 same cycle → next cycle commit_en_out=2'b11 with regs 5,6 and values 7,9; count_out decrements by 2.
- Alloc SW; wb value 0xAB, addr 0x100; st_ack_in after 3 cycles → st_req_out held exactly 4 cycles with addr 0x100, data 0xAB; head advances on the ack cycle only.
- BEQ at head, wb value 1, mispred=1, addr 0x2000, with 5 younger entries → flush_out=1 for one cycle, redirect_pc_out=0x2000, count_out=0, empty_out=1.
- rs1_idx_in=3 while wb channel 2 writes tag 3 value 0x55 → rs1_rdy_out=1, rs1_data_out=0x55 in the same cycle.
- rst_in asserted during store WAIT → st_req_out=0 next cycle, count_out=0, a subsequent st_ack_in is ignored.
